// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup and mispredict/redirect.
// Table and statistics update on the clock edge of a resolve; no backpressure, one resolve per cycle.
module branch_predictor #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    input  logic                 resolve_valid,
    input  logic [WORD_SIZE-1:0] resolve_pc,
    input  logic                 resolve_taken,
    input  logic [WORD_SIZE-1:0] resolve_target,
    input  logic                 resolve_pred_taken,
    input  logic [WORD_SIZE-1:0] resolve_pred_target,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] redirect_pc,
    output logic [15:0]          branch_count,
    output logic [15:0]          mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = WORD_SIZE - IDX_BITS;
    localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(1);

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]    if_tag;
    logic                if_hit;
    logic [IDX_BITS-1:0] res_idx;
    logic [TAG_W-1:0]    res_tag;
    logic                res_hit;

    assign if_idx  = if_pc[IDX_BITS-1:0];
    assign if_tag  = if_pc[WORD_SIZE-1:IDX_BITS];
    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign res_idx = resolve_pc[IDX_BITS-1:0];
    assign res_tag = resolve_pc[WORD_SIZE-1:IDX_BITS];
    assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

    assign pred_taken   = if_hit && ctr_q[if_idx][1];
    assign pred_next_pc = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;

    // A correctly predicted not-taken branch never mispredicts on target.
    assign mispredict  = resolve_valid &&
                         ((resolve_taken != resolve_pred_taken) ||
                          (resolve_taken && (resolve_pred_target != resolve_target)));
    assign redirect_pc = resolve_taken ? resolve_target : resolve_pc + PC_STEP;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q          <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (resolve_valid) begin
            if (res_hit) begin
                if (resolve_taken) begin
                    target_q[res_idx] <= resolve_target;
                    if (ctr_q[res_idx] != 2'b11)
                        ctr_q[res_idx] <= ctr_q[res_idx] + 2'd1;
                end else if (ctr_q[res_idx] != 2'b00) begin
                    ctr_q[res_idx] <= ctr_q[res_idx] - 2'd1;
                end
            end else if (resolve_taken) begin
                // Allocate weakly-taken so one contrary outcome flips the prediction.
                valid_q[res_idx]  <= 1'b1;
                tag_q[res_idx]    <= res_tag;
                target_q[res_idx] <= resolve_target;
                ctr_q[res_idx]    <= 2'b10;
            end
            if (branch_count != 16'hFFFF)
                branch_count <= branch_count + 16'd1;
            if (mispredict && (mispredict_count != 16'hFFFF))
                mispredict_count <= mispredict_count + 16'd1;
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL use parameter WORD_SIZE, default 16, meaning datapath/PC width in bits.
REQ-002 The block SHALL use parameter IDX_BITS, default 4, meaning BTB index width (2^IDX_BITS entries, direct-mapped).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port if_pc  input  WORD_SIZE  fetch-stage PC (word address).
REQ-006 The block SHALL have port pred_taken  output  1  fetch-stage prediction, taken.
REQ-007 The block SHALL have port pred_next_pc  output  WORD_SIZE  predicted next fetch PC.
REQ-008 The block SHALL have port resolve_valid  input  1  a conditional branch resolved this cycle.
REQ-009 The block SHALL have port resolve_pc  input  WORD_SIZE  PC of the resolved branch.
REQ-010 The block SHALL have port resolve_taken  input  1  actual outcome, the branch-condition zero flag.
REQ-011 The block SHALL have port resolve_target  input  WORD_SIZE  computed branch target.
REQ-012 The block SHALL have port resolve_pred_taken  input  1  prediction carried down the pipe with the branch.
REQ-013 The block SHALL have port resolve_pred_target  input  WORD_SIZE  predicted target carried down the pipe.
REQ-014 The block SHALL have port mispredict  output  1  flush request for younger instructions.
REQ-015 The block SHALL have port redirect_pc  output  WORD_SIZE  correct PC when mispredict=1.
REQ-016 The block SHALL have port branch_count  output  16  resolved-branch count, registered.
REQ-017 The block SHALL have port mispredict_count  output  16  mispredict count, registered.

Function
REQ-018 Each entry SHALL hold valid (1b), tag (pc[WORD_SIZE-1:IDX_BITS]), target (WORD_SIZE), ctr (2b saturating: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-019 Lookup SHALL be combinational: idx=if_pc[IDX_BITS-1:0]; hit = valid[idx] && tag[idx]==upper if_pc bits.
REQ-020 pred_taken SHALL equal hit && ctr[idx][1]; pred_next_pc SHALL equal target[idx] if pred_taken, else if_pc+1 (mod 2^WORD_SIZE, FFFF+1=0000).
REQ-021 mispredict SHALL be combinational: resolve_valid && ((resolve_taken!=resolve_pred_taken) || (resolve_taken && resolve_pred_target!=resolve_target)); 0 when resolve_valid=0.
REQ-022 redirect_pc SHALL equal resolve_target if resolve_taken, else resolve_pc+1 (wrapping); value is don't-care when mispredict=0 but SHALL still follow this formula.
REQ-023 On a clock edge with resolve_valid=1 and the resolve entry hitting: taken -> ctr increments saturating at 11 and target<=resolve_target; not-taken -> ctr decrements saturating at 00, target unchanged.
REQ-024 On resolve_valid=1 with a miss (invalid or tag mismatch): taken -> allocate/replace (valid=1, tag, target=resolve_target, ctr=10); not-taken -> no table change.
REQ-025 Updates SHALL become visible to lookup on the cycle after the edge; a same-cycle lookup of the entry being written SHALL return pre-update contents.
REQ-026 branch_count SHALL increment by 1 per edge with resolve_valid=1; mispredict_count by 1 per edge with mispredict=1; both saturate at FFFF.
REQ-027 resolve_valid=0 SHALL leave table and counters unchanged.

Reset
REQ-028 reset_n=0 SHALL immediately, without clock, clear all valid bits, set all ctr to 01, tags/targets to 0, both counts to 0.
REQ-029 During reset pred_taken SHALL be 0 and pred_next_pc SHALL be if_pc+1; reset asserted mid-update SHALL discard that update.
REQ-030 The first update SHALL occur on the first rising edge after reset_n deasserts.

Verification
REQ-031 Cold lookup: after reset, if_pc=0x0010 -> pred_taken=0, pred_next_pc=0x0011.
REQ-032 Allocate: resolve pc=0x0010 taken target=0x0040 pred_taken=0 -> mispredict=1, redirect_pc=0x0040; next cycle if_pc=0x0010 -> pred_taken=1, pred_next_pc=0x0040; mispredict_count=1.
REQ-033 Hysteresis: from ctr=10, one not-taken resolve -> ctr=01, pred_taken=0; two taken -> 11; third taken keeps 11; from 00, not-taken keeps 00.
REQ-034 Alias: entry for 0x0010 valid, taken resolve at 0x0110 target 0x0200 -> entry replaced; lookup 0x0010 misses, 0x0110 predicts 0x0200.
REQ-035 Target mismatch and wrap: pred_taken=1, pred_target=0x0040, actual taken 0x0050 -> mispredict=1, redirect 0x0050; not-taken resolve at 0xFFFF -> redirect_pc=0x0000.
REQ-036 Async reset mid-run with counts nonzero -> counts 0 and pred_taken 0 before next edge; 70000 resolves -> branch_count holds FFFF.
